// File: rtl/calckit_pkg.sv
// rtl/calckit_pkg.sv - shared CalcKit constants, terminator encodings and formatter states
package calckit_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam logic [1:0] TERM_NONE = 2'd0;
    localparam logic [1:0] TERM_CR   = 2'd1;
    localparam logic [1:0] TERM_CRLF = 2'd2;
    localparam logic [1:0] TERM_SP   = 2'd3;

    typedef enum logic [2:0] {
        FMT_IDLE,
        FMT_CONVERT,
        FMT_SEND_DIG,
        FMT_SEND_T1,
        FMT_SEND_T2
    } fmt_state_e;

    function automatic logic [3:0] bcd_digit(input logic [19:0] bcd, input logic [2:0] idx);
        return bcd[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

    function automatic logic [7:0] term_first(input logic [1:0] mode);
        return (mode == TERM_SP) ? ASCII_SP : ASCII_CR;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 16-bit binary to 5-digit BCD, one double-dabble step per cycle
module bin2bcd_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        done_o,
    output logic [19:0] bcd_o
);

    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic [19:0] adj;
    logic [19:0] bcd_d;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < 5; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_d = {adj[18:0], bin_q[15]};
    end

    // done and bcd_o expose the result of the step taken on this edge so the caller
    // can load its first output byte on the same edge as the last iteration.
    assign done_o = busy_q && (cnt_q == 4'd15);
    assign bcd_o  = bcd_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= 16'h0000;
            bcd_q  <= 20'h00000;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= 20'h00000;
            cnt_q  <= 4'd0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bin_q <= {bin_q[14:0], 1'b0};
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/num_tx_formatter.sv
// rtl/num_tx_formatter.sv - prints a 16-bit value as decimal ASCII with optional terminator
import calckit_pkg::*;

module num_tx_formatter #(
    parameter logic [1:0] TERM_MODE = TERM_CRLF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] number_in,
    input  logic        number_valid,
    output logic        number_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    fmt_state_e  state_q;
    logic        ready_q;
    logic        valid_q;
    logic [7:0]  data_q;
    logic [2:0]  ptr_q;
    logic [19:0] digits_q;

    logic        accept;
    logic        bcd_done;
    logic [19:0] bcd_res;
    logic [2:0]  first_ptr;

    assign accept       = number_valid && ready_q;
    assign number_ready = ready_q;
    assign tx_valid     = valid_q;
    assign tx_data      = data_q;

    bin2bcd_seq u_bcd (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (accept),
        .bin_i   (number_in),
        .done_o  (bcd_done),
        .bcd_o   (bcd_res)
    );

    // Highest nonzero nibble wins; an all-zero value falls through to the units digit.
    always_comb begin
        first_ptr = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (bcd_res[4*k +: 4] != 4'd0) begin
                first_ptr = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FMT_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            ptr_q    <= 3'd0;
            digits_q <= 20'h00000;
        end else begin
            case (state_q)
                FMT_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        state_q <= FMT_CONVERT;
                    end
                end
                FMT_CONVERT: begin
                    if (bcd_done) begin
                        digits_q <= bcd_res;
                        ptr_q    <= first_ptr;
                        data_q   <= digit_ascii(bcd_digit(bcd_res, first_ptr));
                        valid_q  <= 1'b1;
                        state_q  <= FMT_SEND_DIG;
                    end
                end
                FMT_SEND_DIG: begin
                    if (tx_ready) begin
                        if (ptr_q == 3'd0) begin
                            if (TERM_MODE == TERM_NONE) begin
                                valid_q <= 1'b0;
                                ready_q <= 1'b1;
                                state_q <= FMT_IDLE;
                            end else begin
                                data_q  <= term_first(TERM_MODE);
                                state_q <= FMT_SEND_T1;
                            end
                        end else begin
                            ptr_q  <= ptr_q - 3'd1;
                            data_q <= digit_ascii(bcd_digit(digits_q, ptr_q - 3'd1));
                        end
                    end
                end
                FMT_SEND_T1: begin
                    if (tx_ready) begin
                        if (TERM_MODE == TERM_CRLF) begin
                            data_q  <= ASCII_LF;
                            state_q <= FMT_SEND_T2;
                        end else begin
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= FMT_IDLE;
                        end
                    end
                end
                FMT_SEND_T2: begin
                    if (tx_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= FMT_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= FMT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_num_tx_formatter.sv
// tb/tb_num_tx_formatter.sv - directed bench for num_tx_formatter in terminator modes 0, 2 and 3
module tb_num_tx_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] number_in;
    logic        number_valid;
    logic        tx_ready;
    int          sel;

    logic        r0, v0, r2, v2, r3, v3;
    logic [7:0]  d0, d2, d3;
    logic        cur_ready, cur_valid;
    logic [7:0]  cur_data;

    logic [7:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    num_tx_formatter #(.TERM_MODE(2'd0)) u_m0 (
        .clk(clk), .rst(rst), .number_in(number_in), .number_valid(number_valid && sel == 0),
        .number_ready(r0), .tx_data(d0), .tx_valid(v0), .tx_ready(tx_ready)
    );
    num_tx_formatter #(.TERM_MODE(2'd2)) u_m2 (
        .clk(clk), .rst(rst), .number_in(number_in), .number_valid(number_valid && sel == 2),
        .number_ready(r2), .tx_data(d2), .tx_valid(v2), .tx_ready(tx_ready)
    );
    num_tx_formatter #(.TERM_MODE(2'd3)) u_m3 (
        .clk(clk), .rst(rst), .number_in(number_in), .number_valid(number_valid && sel == 3),
        .number_ready(r3), .tx_data(d3), .tx_valid(v3), .tx_ready(tx_ready)
    );

    always_comb begin
        case (sel)
            0:       begin cur_ready = r0; cur_valid = v0; cur_data = d0; end
            3:       begin cur_ready = r3; cur_valid = v3; cur_data = d3; end
            default: begin cur_ready = r2; cur_valid = v2; cur_data = d2; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge where tx_valid is first seen high.
    task automatic offer(input logic [15:0] v);
        int n;
        n = 0;
        while (!cur_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("offer_ready", {31'd0, cur_ready}, 32'd1);
        number_in    = v;
        number_valid = 1'b1;
        @(negedge clk);
        number_valid = 1'b0;
        check("ready_low", {31'd0, cur_ready}, 32'd0);
        n = 0;
        while (!cur_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 32'd16);
    endtask

    task automatic collect(input logic [3:0] pat, input bit inject, input int want_cycles);
        logic [7:0] got[$];
        int         cyc;
        logic       pv, pr;
        logic [7:0] pd;
        got = {};
        cyc = 0;
        pv  = 1'b0;
        pr  = 1'b0;
        pd  = 8'h00;
        while (got.size() < exp_q.size() && cyc < 200) begin
            if (pv && !pr) begin
                check("hold_valid", {31'd0, cur_valid}, 32'd1);
                check("hold_data", {24'd0, cur_data}, {24'd0, pd});
            end
            tx_ready     = pat[cyc[1:0]];
            number_valid = inject && (cyc == 1);
            if (cur_valid && tx_ready) got.push_back(cur_data);
            pv = cur_valid;
            pr = tx_ready;
            pd = cur_data;
            @(negedge clk);
            cyc++;
        end
        number_valid = 1'b0;
        tx_ready     = 1'b0;
        check("nbytes", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check("byte", {24'd0, got[i]}, {24'd0, exp_q[i]});
        end
        check("cycles", cyc, want_cycles);
        check("ready_after", {31'd0, cur_ready}, 32'd1);
        check("valid_after", {31'd0, cur_valid}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        number_in    = 16'h0000;
        number_valid = 1'b0;
        tx_ready     = 1'b0;
        sel          = 2;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready2", {31'd0, r2}, 32'd1);
        check("rst_valid2", {31'd0, v2}, 32'd0);
        check("rst_data2", {24'd0, d2}, 32'd0);
        check("rst_ready0", {31'd0, r0}, 32'd1);
        check("rst_valid3", {31'd0, v3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        offer(16'd123);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 5);

        offer(16'd0);
        exp_q = '{8'h30, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 3);

        offer(16'd65535);
        exp_q = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 7);

        offer(16'd1005);
        exp_q = '{8'h31, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 6);

        // ready pattern 1-0-0-1 repeating, with a stray number_valid while busy
        offer(16'd42);
        exp_q = '{8'h34, 8'h32, 8'h0D, 8'h0A};
        collect(4'b1001, 1'b1, 8);
        repeat (20) @(negedge clk);
        check("no_queue_valid", {31'd0, cur_valid}, 32'd0);
        check("no_queue_ready", {31'd0, cur_ready}, 32'd1);

        sel = 0;
        offer(16'd7);
        exp_q = '{8'h37};
        collect(4'b1111, 1'b0, 1);

        sel = 3;
        offer(16'd7);
        exp_q = '{8'h37, 8'h20};
        collect(4'b1111, 1'b0, 2);

        // reset during CONVERT
        sel          = 2;
        number_in    = 16'd55;
        number_valid = 1'b1;
        @(negedge clk);
        number_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstc_ready", {31'd0, cur_ready}, 32'd1);
        check("rstc_valid", {31'd0, cur_valid}, 32'd0);
        repeat (20) @(negedge clk);
        check("rstc_quiet", {31'd0, cur_valid}, 32'd0);

        offer(16'd123);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 5);

        // reset after the second digit has been sent
        offer(16'd4567);
        tx_ready = 1'b1;
        check("rsts_d0", {24'd0, cur_data}, 32'h34);
        @(negedge clk);
        check("rsts_d1", {24'd0, cur_data}, 32'h35);
        @(negedge clk);
        tx_ready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsts_ready", {31'd0, cur_ready}, 32'd1);
        check("rsts_valid", {31'd0, cur_valid}, 32'd0);

        offer(16'd8);
        exp_q = '{8'h38, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 3);

        // back-to-back values
        offer(16'd9);
        exp_q = '{8'h39, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 3);
        offer(16'd10);
        exp_q = '{8'h31, 8'h30, 8'h0D, 8'h0A};
        collect(4'b1111, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/num_tx_formatter.md
# num_tx_formatter

Converts a 16-bit unsigned result into decimal ASCII and streams it byte-by-byte to the UART transmitter. Leading zeros are suppressed, and an optional line terminator is appended. It sits between the CalcKit result path and the UART TX byte interface. It is the output-side counterpart of the command parser that turns ASCII digits into numbers.

## Interface
Parameters:
- `TERM_MODE`, default 2: terminator appended after the digits.
  - 0 = none
  - 1 = CR (0x0D)
  - 2 = CR LF (0x0D 0x0A)
  - 3 = space (0x20)

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `number_in`  in  16  unsigned value to print, 0–65535.
- `number_valid`  in  1  `number_in` is offered this cycle.
- `number_ready`  out  1  block idle. It accepts when `number_valid && number_ready` at a rising edge.
- `tx_data`  out  8  ASCII byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the transmitter accepts a byte this cycle.

## Operation
- All outputs are registered.
- Reset values: `number_ready`=1, `tx_valid`=0, `tx_data`=0x00. Internal state returns to IDLE.
- States: IDLE → CONVERT → SEND_DIG → SEND_T1 → SEND_T2 → IDLE.
- **IDLE**
  - `number_ready`=1.
  - On accept, latch `number_in`, clear the 20-bit BCD register and bit counter, set `number_ready`=0, and go to CONVERT.
- **CONVERT**
  - Runs 16 iterations of double-dabble, one per cycle, MSB first.
  - Before each shift, add 3 to every BCD nibble ≥5.
  - After the 16th iteration:
    - Select the first digit as the most-significant nonzero nibble, or nibble 0 if the value is 0.
    - Load `tx_data` = 0x30 + digit, set `tx_valid`=1, and go to SEND_DIG.
- **SEND_DIG**
  - On `tx_valid && tx_ready`, advance to the next lower nibble and load its ASCII code.
  - After the units digit is accepted:
    - TERM_MODE 0: `tx_valid`=0, go to IDLE.
    - Otherwise: load the first terminator byte and go to SEND_T1.
- **SEND_T1**
  - On accept: if TERM_MODE=2, load 0x0A and go to SEND_T2; otherwise `tx_valid`=0 and go to IDLE.
- **SEND_T2**
  - On accept: `tx_valid`=0, go to IDLE.
- Handshake rules:
  - Once `tx_valid`=1, `tx_data` holds stable until the accepting edge.
  - `tx_valid` never drops without a transfer, except on reset.
  - `tx_ready` while `tx_valid`=0 has no effect.
- Zero prints as the single character "0". Embedded zeros are printed (e.g. 1005 → "1005").
- `number_valid` while busy is ignored. It is not queued.
- `rst` asserted mid-conversion or mid-transmission aborts immediately. The partial string is not completed.

## Timing
- Accept edge E0.
  - `number_ready` is low from the cycle after E0.
  - CONVERT occupies edges E1–E16.
  - `tx_valid` is first high after E16, i.e. 16 cycles after `number_ready` falls.
- With `tx_ready` held high, one byte transfers per cycle. A value with d digits and t terminator bytes transfers its last byte at E16+d+t.
- `number_ready` rises on the edge that accepts the final byte. It is high the following cycle, so back-to-back numbers are possible.
- Each `tx_ready` low cycle adds exactly one cycle of stall. No bytes are dropped.

## Structure
- Shared `calckit_pkg`:
  - ASCII constants: `ASCII_0` (0x30), `ASCII_CR` (0x0D), `ASCII_LF` (0x0A), `ASCII_SP` (0x20).
  - `TERM_*` encodings.
  - Formatter state encodings.
- The parser's delimiter set (CR, LF, space) uses the same constants.
- One sub-module, `bin2bcd_seq`:
  - Start/done pulse handshake.
  - 16-bit in, 20-bit BCD out.
  - 16 cycles; the `done` pulse coincides with E16.
- The top level holds the FSM, digit pointer, leading-zero select and terminator sequencing.

## Test plan
- 123, TERM_MODE 2, `tx_ready`=1 → bytes 0x31 0x32 0x33 0x0D 0x0A on consecutive cycles. First `tx_valid` 16 cycles after `number_ready` falls.
- 0 → single byte 0x30, then terminator. 65535 → 0x36 0x35 0x35 0x33 0x35. 1005 → 0x31 0x30 0x30 0x35.
- 42 with `tx_ready` toggling 1-0-0-1 → `tx_data` stable through stalls, each byte transferred exactly once. `number_valid` pulsed mid-send → ignored.
- TERM_MODE 0 and 3, value 7 → "7" only, or "7" then 0x20. `number_ready` high the cycle after the last transfer.
- `rst` asserted while CONVERT is in progress and again after the second digit is sent → `tx_valid`=0 and `number_ready`=1 the next cycle. The next value prints correctly.
- Two values offered back-to-back (9 then 10) → "9\r\n10\r\n" with no lost or duplicated bytes.
